// File: rtl/rv_pkg.sv
// Shared RV32I register-file types and constants.
// Address width and register count are fixed by the ISA.
package rv_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int WORD_SIZE  = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [NUM_REGS-1:0]   reg_mask_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

  // One-hot mask for a register; x0 never gets a bit.
  function automatic reg_mask_t reg_onehot(
    input logic      en,
    input reg_addr_t addr
  );
    reg_mask_t m;
    m = '0;
    if (en && addr != ZERO_REG) begin
      m[addr] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/register_file_if.sv
// Decode/writeback side bundle of the register file:
// write port, two read ports, issue marks and stall.
interface register_file_if
  import rv_pkg::*;
#(
  parameter int WORD_SIZE = rv_pkg::WORD_SIZE
);

  logic                 write_enable;
  reg_addr_t            write_addr;
  logic [WORD_SIZE-1:0] write_data;

  logic                 read_enable;
  reg_addr_t            rs1_addr;
  reg_addr_t            rs2_addr;
  logic [WORD_SIZE-1:0] rs1_data;
  logic [WORD_SIZE-1:0] rs2_data;

  logic                 issue_valid;
  reg_addr_t            issue_rd;
  logic                 read_stall;

  modport master (
    output write_enable,
    output write_addr,
    output write_data,
    output read_enable,
    output rs1_addr,
    output rs2_addr,
    output issue_valid,
    output issue_rd,
    input  rs1_data,
    input  rs2_data,
    input  read_stall
  );

  modport slave (
    input  write_enable,
    input  write_addr,
    input  write_data,
    input  read_enable,
    input  rs1_addr,
    input  rs2_addr,
    input  issue_valid,
    input  issue_rd,
    output rs1_data,
    output rs2_data,
    output read_stall
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register,
// set on issue, cleared on writeback, drives RAW stall.
module reg_scoreboard
  import rv_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      issue_valid,
  input  reg_addr_t issue_rd,
  input  logic      write_enable,
  input  reg_addr_t write_addr,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  output logic      read_stall
);

  reg_mask_t pending;
  reg_mask_t pending_next;
  reg_mask_t set_mask;
  reg_mask_t clr_mask;
  logic      hit1;
  logic      hit2;
  logic      byp1;
  logic      byp2;

  // Issue outranks writeback on the same register.
  always_comb begin
    set_mask     = reg_onehot(issue_valid, issue_rd);
    clr_mask     = reg_onehot(write_enable, write_addr);
    pending_next = (pending & ~clr_mask) | set_mask;
    pending_next[ZERO_REG] = 1'b0;
  end

  // Pending bits register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // A same-cycle write resolves the hazard via bypass.
  always_comb begin
    hit1 = pending[rs1_addr];
    hit2 = pending[rs2_addr];
    byp1 = write_enable && (write_addr == rs1_addr);
    byp2 = write_enable && (write_addr == rs2_addr);
    read_stall = (hit1 && !byp1) || (hit2 && !byp2);
  end

endmodule

// File: rtl/register_file.sv
// RV32I architectural register file: storage, write port,
// registered dual read with write bypass, RAW scoreboard.
module register_file
  import rv_pkg::*;
#(
  parameter int WORD_SIZE = rv_pkg::WORD_SIZE
)(
  input logic            clock,
  input logic            reset,
  register_file_if.slave bus
);

  logic [WORD_SIZE-1:0] regs [NUM_REGS];
  logic [WORD_SIZE-1:0] rs1_next;
  logic [WORD_SIZE-1:0] rs2_next;
  logic                 wr_ok;

  assign wr_ok = bus.write_enable
              && (bus.write_addr != ZERO_REG);

  // Architectural storage; x0 is never written.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[bus.write_addr] <= bus.write_data;
    end
  end

  // Port 1 source: zero, bypassed write, or storage.
  always_comb begin
    rs1_next = regs[bus.rs1_addr];
    unique case (1'b1)
      bus.rs1_addr == ZERO_REG:
        rs1_next = '0;
      wr_ok && (bus.write_addr == bus.rs1_addr):
        rs1_next = bus.write_data;
      default:
        rs1_next = regs[bus.rs1_addr];
    endcase
  end

  // Port 2 source: zero, bypassed write, or storage.
  always_comb begin
    rs2_next = regs[bus.rs2_addr];
    unique case (1'b1)
      bus.rs2_addr == ZERO_REG:
        rs2_next = '0;
      wr_ok && (bus.write_addr == bus.rs2_addr):
        rs2_next = bus.write_data;
      default:
        rs2_next = regs[bus.rs2_addr];
    endcase
  end

  // Read ports capture on read_enable, else hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.rs1_data <= '0;
      bus.rs2_data <= '0;
    end else if (bus.read_enable) begin
      bus.rs1_data <= rs1_next;
      bus.rs2_data <= rs2_next;
    end
  end

  reg_scoreboard u_scoreboard (
    .clock        (clock),
    .reset        (reset),
    .issue_valid  (bus.issue_valid),
    .issue_rd     (bus.issue_rd),
    .write_enable (bus.write_enable),
    .write_addr   (bus.write_addr),
    .rs1_addr     (bus.rs1_addr),
    .rs2_addr     (bus.rs2_addr),
    .read_stall   (bus.read_stall)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed table,
// async reset sequence, random traffic vs. reference model.
module tb_register_file;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        iv;
    logic [4:0]  ird;
    logic        st;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  register_file_if bus ();

  register_file dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  bit          m_pend [32];
  logic [31:0] m_rs1;
  logic [31:0] m_rs2;

  vec_t vecs [22];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_rs1 = '0;
    m_rs2 = '0;
  endfunction

  function automatic logic model_stall(input vec_t v);
    logic s1;
    logic s2;
    s1 = v.r1 != 0 && m_pend[v.r1]
      && !(v.we && v.wa == v.r1);
    s2 = v.r2 != 0 && m_pend[v.r2]
      && !(v.we && v.wa == v.r2);
    return s1 || s2;
  endfunction

  function automatic logic [31:0] model_read(
    input vec_t v, input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (v.we && v.wa == a) return v.wd;
    return m_regs[a];
  endfunction

  function automatic void model_edge(input vec_t v);
    if (v.re) begin
      m_rs1 = model_read(v, v.r1);
      m_rs2 = model_read(v, v.r2);
    end
    if (v.we && v.wa != 0) begin
      m_regs[v.wa] = v.wd;
      m_pend[v.wa] = 1'b0;
    end
    if (v.iv && v.ird != 0) m_pend[v.ird] = 1'b1;
  endfunction

  function automatic vec_t mk(
    input logic we, input logic [4:0] wa,
    input logic [31:0] wd, input logic re,
    input logic [4:0] r1, input logic [4:0] r2,
    input logic iv, input logic [4:0] ird,
    input logic st, input logic [31:0] e1,
    input logic [31:0] e2);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re;
    v.r1 = r1; v.r2 = r2; v.iv = iv; v.ird = ird;
    v.st = st; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.write_enable = v.we;
    bus.write_addr   = v.wa;
    bus.write_data   = v.wd;
    bus.read_enable  = v.re;
    bus.rs1_addr     = v.r1;
    bus.rs2_addr     = v.r2;
    bus.issue_valid  = v.iv;
    bus.issue_rd     = v.ird;
  endtask

  // Called at posedge+1; ends at the next posedge+1.
  task automatic step(input vec_t v, input bit tab,
                      input string tag);
    logic xs;
    drive(v);
    #1;
    xs = tab ? v.st : model_stall(v);
    chk({tag, "_stall"}, {31'd0, bus.read_stall},
        {31'd0, xs});
    @(posedge clock);
    model_edge(v);
    #1;
    chk({tag, "_rs1"}, bus.rs1_data, tab ? v.e1 : m_rs1);
    chk({tag, "_rs2"}, bus.rs2_data, tab ? v.e2 : m_rs2);
  endtask

  function automatic vec_t rnd_vec();
    vec_t v;
    v.we  = 1'($urandom_range(0, 1));
    v.wa  = 5'($urandom_range(0, 7));
    v.wd  = $urandom;
    v.re  = 1'($urandom_range(0, 3) != 0);
    v.r1  = 5'($urandom_range(0, 7));
    v.r2  = 5'($urandom_range(0, 7));
    v.iv  = 1'($urandom_range(0, 2) == 0);
    v.ird = 5'($urandom_range(0, 7));
    v.st  = 1'b0;
    v.e1  = '0;
    v.e2  = '0;
    return v;
  endfunction

  initial begin
    vec_t v;
    vecs[0]  = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd2,
                  1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    vecs[1]  = mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0,
                  5'd0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    vecs[2]  = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0,
                  1'b0, 5'd0, 1'b0, 32'hDEADBEEF, 32'h0);
    vecs[3]  = mk(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 5'd5,
                  1'b0, 5'd0, 1'b0, 32'h0, 32'hDEADBEEF);
    vecs[4]  = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0,
                  1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    vecs[5]  = mk(1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7,
                  5'd7, 1'b0, 5'd0, 1'b0, 32'hA5A5A5A5,
                  32'hA5A5A5A5);
    vecs[6]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd7,
                  1'b1, 5'd3, 1'b0, 32'hA5A5A5A5,
                  32'hA5A5A5A5);
    vecs[7]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd7,
                  1'b0, 5'd0, 1'b1, 32'hA5A5A5A5,
                  32'hA5A5A5A5);
    vecs[8]  = mk(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 5'd3,
                  1'b0, 5'd0, 1'b0, 32'h11, 32'h11);
    vecs[9]  = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3,
                  1'b0, 5'd0, 1'b0, 32'h11, 32'h11);
    vecs[10] = mk(1'b1, 5'd4, 32'h22, 1'b1, 5'd0, 5'd0,
                  1'b1, 5'd4, 1'b0, 32'h0, 32'h0);
    vecs[11] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd4,
                  1'b0, 5'd0, 1'b1, 32'h0, 32'h22);
    vecs[12] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd4,
                  1'b0, 5'd0, 1'b1, 32'h0, 32'h22);
    vecs[13] = mk(1'b1, 5'd4, 32'h33, 1'b1, 5'd0, 5'd4,
                  1'b0, 5'd0, 1'b0, 32'h0, 32'h33);
    vecs[14] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd4,
                  1'b0, 5'd0, 1'b0, 32'h0, 32'h33);
    vecs[15] = mk(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd4,
                  1'b0, 5'd0, 1'b0, 32'h99, 32'h33);
    vecs[16] = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd4,
                  1'b1, 5'd10, 1'b0, 32'h99, 32'h33);
    vecs[17] = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd10, 5'd0,
                  1'b1, 5'd10, 1'b1, 32'h99, 32'h33);
    vecs[18] = mk(1'b1, 5'd10, 32'hABC, 1'b1, 5'd10,
                  5'd0, 1'b0, 5'd0, 1'b0, 32'hABC, 32'h0);
    vecs[19] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 5'd0,
                  1'b0, 5'd0, 1'b0, 32'hABC, 32'h0);
    vecs[20] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0,
                  1'b1, 5'd0, 1'b0, 32'h0, 32'h0);
    vecs[21] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0,
                  1'b0, 5'd0, 1'b0, 32'h0, 32'h0);

    v = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0,
           1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    drive(v);
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("reset_rs1", bus.rs1_data, 32'h0);
    chk("reset_rs2", bus.rs2_data, 32'h0);
    chk("reset_stall", {31'd0, bus.read_stall}, 32'h0);

    for (int i = 0; i < 22; i++) begin
      step(vecs[i], 1'b1, $sformatf("vec%0d", i));
    end

    // Populate every register, leave x6 pending.
    for (int a = 1; a < 32; a++) begin
      v = mk(1'b1, 5'(a), $urandom, 1'b1, 5'(a), 5'(32 - a),
             1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
      step(v, 1'b0, $sformatf("fill%0d", a));
    end
    v = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 5'd9,
           1'b1, 5'd6, 1'b0, 32'h0, 32'h0);
    step(v, 1'b0, "pre_rst");

    // Write in flight when reset hits between edges.
    v = mk(1'b1, 5'd12, 32'h12345678, 1'b1, 5'd6, 5'd12,
           1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    drive(v);
    #1;
    chk("mid_stall_pre", {31'd0, bus.read_stall}, 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rs1", bus.rs1_data, 32'h0);
    chk("mid_rs2", bus.rs2_data, 32'h0);
    chk("mid_stall", {31'd0, bus.read_stall}, 32'h0);
    @(posedge clock);
    #1;
    v.we = 1'b0;
    drive(v);
    reset = 1'b0;
    model_reset();

    for (int a = 1; a < 32; a++) begin
      v = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 5'(32 - a),
             1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
      step(v, 1'b0, $sformatf("post%0d", a));
    end

    for (int n = 0; n < 400; n++) begin
      step(rnd_vec(), 1'b0, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Architectural integer register file for the RV32I pipeline: the receiving end of the writeback stage's write port (write_data / write_addr / write_enable_out). Provides two registered read ports to decode, write-to-read bypass, and a pending-write scoreboard that flags RAW hazards so decode can stall. Sits inside the decode stage; all writes come from writeback, all reads and issue marks from decode.

## Interface
- WORD_SIZE, 32, data width of each register
- NUM_REGS, 32, register count; address width is 5 bits, fixed
- clock  input  1  single clock; all state updates on posedge
- reset  input  1  asynchronous, active-high; clears all state
- write_enable  input  1  write strobe from writeback
- write_addr  input  5  destination register of the write
- write_data  input  WORD_SIZE  value to write
- read_enable  input  1  capture read ports this cycle
- rs1_addr  input  5  source register 1
- rs2_addr  input  5  source register 2
- rs1_data  output  WORD_SIZE  registered read data, port 1
- rs2_data  output  WORD_SIZE  registered read data, port 2
- issue_valid  input  1  decode issues an instruction that will write issue_rd
- issue_rd  input  5  destination of the issued instruction
- read_stall  output  1  combinational: rs1 or rs2 has an unresolved pending write

## Operation
- Storage: NUM_REGS x WORD_SIZE flops; x0 reads 0 always, never written.
- Write: on posedge with write_enable=1 and write_addr!=0, regs[write_addr] <= write_data. write_addr=0 ignored.
- Read: on posedge with read_enable=1, rsN_data <= 0 if rsN_addr=0; else write_data if write_enable=1 and write_addr=rsN_addr; else regs[rsN_addr]. read_enable=0: rsN_data hold.
- Scoreboard: pending[31:1] bits, pending[0] constant 0.
  - issue_valid=1, issue_rd!=0: pending[issue_rd] set at posedge.
  - write_enable=1, write_addr!=0: pending[write_addr] cleared at posedge.
  - Same cycle, same nonzero register, both events: pending ends set (issue wins; the new instruction is still in flight).
  - Write to a non-pending register: legal, data written, pending unchanged (0).
  - One bit per register; a second issue to an already-pending rd keeps it set, and the first matching write clears it. Decode must not issue a second writer to a pending rd; no counting is done.
- read_stall = (pending[rs1_addr] and not (write_enable and write_addr=rs1_addr)) or same for rs2. A write in the current cycle resolves the hazard because the bypass supplies the data. Addresses of 0 never stall.
- read_stall does not depend on read_enable; decode gates it.

## Timing
- Reset (async assert, released synchronously by the clock domain): all regs 0, pending all 0, rs1_data=rs2_data=0, read_stall=0.
- Reset asserted mid-operation: all state cleared immediately, and the in-progress write is lost.
- Write latency: written value is visible in regs the cycle after the write edge. Visible on rsN_data at the same edge via bypass.
- Read latency: 1 cycle, address at edge N gives data valid after edge N.
- read_stall: combinational from rs1_addr, rs2_addr, pending, write_enable, write_addr; no latency.
- No backpressure on the write port; every write_enable=1 cycle is consumed.

## Structure
- Shared package rv_pkg: REG_ADDR_W=5, NUM_REGS=32, ZERO_REG=5'd0, WORD_SIZE default.
- Sub-module reg_scoreboard: pending bits, set/clear priority, read_stall logic. Parent holds storage, the write port, and the registered read/bypass.

## Test plan
- Reset then read x1,x2 with read_enable=1: rs1_data=rs2_data=0, read_stall=0.
- Write x5=0xDEADBEEF, next cycle read rs1=5, rs2=0: rs1_data=0xDEADBEEF, rs2_data=0; write x0=0x1234 then read x0: 0.
- Same-cycle write x7=0xA5A5A5A5 and read rs1=7, rs2=7: both outputs 0xA5A5A5A5 after that edge.
- Issue rd=3, next cycle rs1=3: read_stall=1; cycle with write x3=0x11: read_stall=0 and rs1_data=0x11; afterwards pending[3]=0.
- Issue rd=4 and write x4=0x22 on the same edge: x4=0x22 stored, pending[4]=1, rs2=4 stalls until the next write to x4.
- Populate x1..x31, assert reset asynchronously between edges: outputs 0 immediately, all reads return 0, read_stall=0.
